// File: rtl/load_store_unit.sv
// RISC-V load/store initiator for a word-organised data memory.
// Handles byte/halfword lanes, load extension and read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter bit          CHECK_RANGE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_error,
  output logic [31:0]           resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  mem_write_enable,
  input  logic [31:0]           mem_read_data
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_READ, S_WRITE, S_ERR} state_e;

  state_e                state_q, state_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            offset_q, offset_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  we_q, we_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_error_q, resp_error_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  req_err;
  logic [4:0]            lane_shift;
  logic [31:0]           shifted;
  logic [31:0]           load_data;
  logic [31:0]           lane_mask;
  logic [31:0]           merged;

  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr[0];
      3'b010:  req_err = |req_addr[1:0];
      3'b100:  req_err = req_write;
      3'b101:  req_err = req_write | req_addr[0];
      default: req_err = 1'b1;
    endcase
    if (CHECK_RANGE && ((req_addr >> ADDR_WIDTH) != 32'd0)) req_err = 1'b1;
  end

  // Halfword offsets are always 0 or 2 here, so one shifter serves both widths.
  assign lane_shift = {offset_q, 3'b000};
  assign shifted    = mem_read_data >> lane_shift;

  always_comb begin
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign lane_mask = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shift;
  assign merged    = (mem_read_data & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    wdata_d      = wdata_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    we_d         = 1'b0;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    rdata_d      = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          offset_d = req_addr[1:0];
          wdata_d  = req_wdata;
          addr_d   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          if (req_err) begin
            state_d = S_ERR;
          end else if (!req_write) begin
            state_d = S_LOAD;
          end else if (req_funct3 == 3'b010) begin
            state_d   = S_WRITE;
            wr_data_d = req_wdata;
            we_d      = 1'b1;
          end else begin
            state_d = S_RMW_READ;
          end
        end
      end
      S_LOAD: begin
        rdata_d      = load_data;
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      S_RMW_READ: begin
        wr_data_d = merged;
        we_d      = 1'b1;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      S_ERR: begin
        resp_valid_d = 1'b1;
        resp_error_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      funct3_q     <= 3'd0;
      offset_q     <= 2'd0;
      wdata_q      <= 32'd0;
      addr_q       <= '0;
      wr_data_q    <= 32'd0;
      we_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
      wdata_q      <= wdata_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      we_q         <= we_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      rdata_q      <= rdata_d;
    end
  end

  assign req_ready        = (state_q == S_IDLE);
  assign resp_valid       = resp_valid_q;
  assign resp_error       = resp_error_q;
  assign resp_rdata       = rdata_q;
  assign mem_address      = addr_q;
  assign mem_write_data   = wr_data_q;
  // A reset arriving during WRITE must kill the strobe before the memory's clock edge.
  assign mem_write_enable = we_q & ~reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses,
// a negedge monitor pops and compares data, error flag, latency and write-strobe count.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic [16:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  load_store_unit #(.ADDR_WIDTH(17), .CHECK_RANGE(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:32767];
  assign mem_read_data = mem[mem_address[16:2]];

  int cyc = 0;
  int wr_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write_enable) begin
      mem[mem_address[16:2]] <= mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          writes;
    int          acc_cyc;
    int          wr_snap;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;
  int txn = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        txn++;
        chk($sformatf("t%0d_error", txn), {31'd0, resp_error}, {31'd0, e.err});
        chk($sformatf("t%0d_rdata", txn), resp_rdata, e.rdata);
        chk($sformatf("t%0d_latency", txn), cyc - e.acc_cyc, e.lat);
        chk($sformatf("t%0d_writes", txn), wr_cnt - e.wr_snap, e.writes);
        chk($sformatf("t%0d_ready", txn), {31'd0, req_ready}, 32'd1);
      end
    end
  end

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                       input int lat, input int writes);
    int n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 50 cycles");
      return;
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    e.err = err; e.rdata = rdata; e.lat = lat; e.writes = writes;
    e.acc_cyc = cyc; e.wr_snap = wr_cnt;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    logic [31:0] saved;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", {15'd0, mem_address}, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    chk("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
    reset = 1'b0;

    // write, f3, addr, wdata, err, rdata, latency, strobes
    issue(1, 3'b010, 32'h10, 32'h80FF7F01, 0, 32'h0, 2, 1);
    issue(0, 3'b000, 32'h11, 32'h0, 0, 32'h0000007F, 2, 0);
    issue(0, 3'b000, 32'h12, 32'h0, 0, 32'hFFFFFFFF, 2, 0);
    issue(0, 3'b100, 32'h13, 32'h0, 0, 32'h00000080, 2, 0);
    issue(0, 3'b001, 32'h12, 32'h0, 0, 32'hFFFF80FF, 2, 0);
    issue(0, 3'b101, 32'h12, 32'h0, 0, 32'h000080FF, 2, 0);
    issue(0, 3'b010, 32'h10, 32'h0, 0, 32'h80FF7F01, 2, 0);
    issue(0, 3'b000, 32'h10, 32'h0, 0, 32'h00000001, 2, 0);
    issue(0, 3'b001, 32'h10, 32'h0, 0, 32'h00007F01, 2, 0);
    issue(0, 3'b000, 32'h13, 32'h0, 0, 32'hFFFFFF80, 2, 0);
    drain();

    issue(1, 3'b010, 32'h10, 32'h11223344, 0, 32'h0, 2, 1);
    issue(1, 3'b000, 32'h12, 32'h000000AB, 0, 32'h0, 3, 1);
    drain();
    chk("mem_sb_0x12", mem[4], 32'h11AB3344);
    issue(1, 3'b000, 32'h13, 32'hFFFFFF55, 0, 32'h0, 3, 1);
    issue(0, 3'b010, 32'h10, 32'h0, 0, 32'h55AB3344, 2, 0);

    issue(1, 3'b010, 32'h20, 32'hDEADBEEF, 0, 32'h0, 2, 1);
    drain();
    chk("mem_sw_0x20", mem[8], 32'hDEADBEEF);
    issue(1, 3'b001, 32'h22, 32'h0000CAFE, 0, 32'h0, 3, 1);
    drain();
    chk("mem_sh_0x22", mem[8], 32'hCAFEBEEF);
    issue(1, 3'b001, 32'h20, 32'h12345678, 0, 32'h0, 3, 1);
    issue(0, 3'b010, 32'h20, 32'h0, 0, 32'hCAFE5678, 2, 0);

    issue(0, 3'b010, 32'h21, 32'h0, 1, 32'h0, 2, 0);
    issue(1, 3'b001, 32'h23, 32'hFFFF, 1, 32'h0, 2, 0);
    issue(0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 2, 0);
    issue(0, 3'b010, 32'h0002_0000, 32'h0, 1, 32'h0, 2, 0);
    issue(1, 3'b010, 32'h0002_0010, 32'h0BADF00D, 1, 32'h0, 2, 0);
    issue(1, 3'b100, 32'h10, 32'h000000EE, 1, 32'h0, 2, 0);
    issue(1, 3'b101, 32'h10, 32'h0000EEEE, 1, 32'h0, 2, 0);
    issue(0, 3'b001, 32'h11, 32'h0, 1, 32'h0, 2, 0);
    issue(0, 3'b110, 32'h10, 32'h0, 1, 32'h0, 2, 0);
    issue(1, 3'b111, 32'h10, 32'h0, 1, 32'h0, 2, 0);
    issue(0, 3'b010, 32'h10, 32'h0, 0, 32'h55AB3344, 2, 0);
    drain();
    chk("mem_after_errors", mem[4], 32'h55AB3344);

    // Reset while the SB sits in WRITE: the memory word must not change.
    saved = mem[4];
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h11;
    req_wdata  = 32'h00000077;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_write_enable && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rmw_reached_write", {31'd0, mem_write_enable}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_gates_we", {31'd0, mem_write_enable}, 32'd0);
    @(negedge clk);
    chk("rst_mid_sb_mem", mem[4], saved);
    chk("rst_mid_sb_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_sb_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mid_sb_rdata", resp_rdata, 32'd0);
    chk("rst_mid_sb_addr", {15'd0, mem_address}, 32'd0);
    chk("rst_mid_sb_wdata", mem_write_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(0, 3'b010, 32'h10, 32'h0, 0, 32'h55AB3344, 2, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
